sl_receiver: RTL and testbench

//  SL-link receive stage; sits downstream of the SL transmitter on the SL0/SL1 pair.

---
 rtl/sl_receiver.sv | 249 ++++++++++++++++++++++++
 tb/tb_sl_receiver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sl_receiver.sv
// sl_receiver: SL-link receive stage on the SL0/SL1 pair.
// Decodes LSB-first words of BQ (8..32, even) bits followed by one odd-parity
// symbol, and presents rxdata/status/config on a 32-bit register port.
// Optional build macro: SL_RX_FILTER_EN adds a 3-sample majority filter per line.
// Config layout: [0] IRQM, [6:1] BQ, [10:8] FQ. Status layout: [0] RIP,
// [8] DR, [9] PE, [10] LE, [11] TO, [12] OVR.
module sl_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int TO_MULT     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SL0,
  input  logic        SL1,
  input  logic [31:0] d_in,
  input  logic        addr,
  input  logic        wr_en,
  output logic [31:0] d_out,
  output logic        irq
);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    SYMBOL    = 3'd2,
    GAP       = 3'd3,
    STOP      = 3'd4
  } state_t;

  localparam logic [1:0] LN_IDLE = 2'b11;
  localparam logic [1:0] LN_ZERO = 2'b10;
  localparam logic [1:0] LN_ONE  = 2'b01;
  localparam logic [1:0] LN_STOP = 2'b00;

  // Odd-parity check over data bits [bq-1:0] plus the parity symbol at [bq].
  function automatic logic parity_ok(input logic [32:0] sh, input logic [5:0] bq);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 33; i++) begin
      if (i <= int'(bq)) p = p ^ sh[i];
    end
    return p;
  endfunction

  // Keep only the BQ data bits, zero above.
  function automatic logic [31:0] data_of(input logic [32:0] sh, input logic [5:0] bq);
    logic [31:0] d;
    d = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(bq)) d[i] = sh[i];
    end
    return d;
  endfunction

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Synchronisers reset to 0 so the FSM sees "stop" (not idle) right after
  // reset and cannot mistake the middle of a frame for a line-idle condition.
  logic [SYNC_STAGES-1:0] sync0_q, sync1_q;
  logic                   s0, s1;

  // Bring the asynchronous SL lines into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      sync0_q <= {sync0_q[SYNC_STAGES-2:0], SL0};
      sync1_q <= {sync1_q[SYNC_STAGES-2:0], SL1};
    end
  end

`ifdef SL_RX_FILTER_EN
  logic [2:0] filt0_q, filt1_q;

  // Three-sample history per line; a single-clock pulse never wins the vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt0_q <= 3'b000;
      filt1_q <= 3'b000;
    end else begin
      filt0_q <= {filt0_q[1:0], sync0_q[SYNC_STAGES-1]};
      filt1_q <= {filt1_q[1:0], sync1_q[SYNC_STAGES-1]};
    end
  end

  assign s0 = maj3(filt0_q);
  assign s1 = maj3(filt1_q);
`else
  assign s0 = sync0_q[SYNC_STAGES-1];
  assign s1 = sync1_q[SYNC_STAGES-1];
`endif

  state_t      state_q;
  logic [10:0] cfg_q;
  logic [1:0]  ln_q, sym_q;
  logic [15:0] tmr_q;
  logic [32:0] shift_q;
  logic [5:0]  n_q;
  logic [31:0] rxdata_q;
  logic        dr_q, pe_q, le_q, to_q, ovr_q;

  logic [1:0]  line;
  logic [5:0]  bq;
  logic [2:0]  fq;
  logic [5:0]  hb;
  logic [15:0] limit;
  logic        active, tmo, bit_s, reg_wr, cfg_ok;
  logic [15:0] status;
  logic        unused_d_in;

  assign line   = {s1, s0};
  assign bq     = cfg_q[6:1];
  assign fq     = cfg_q[10:8];
  assign bit_s  = (line == LN_ONE);
  assign active = (state_q == SYMBOL) || (state_q == GAP) || (state_q == STOP);
  assign reg_wr = wr_en && !addr;
  assign limit  = 16'(TO_MULT) * {10'd0, hb};
  assign tmo    = active && (line == ln_q) && (tmr_q == limit - 16'd1);
  assign cfg_ok = reg_wr && !d_in[1] && (d_in[6:1] >= 6'd8) && (d_in[6:1] <= 6'd32) &&
                  ((state_q == IDLE) || (state_q == WAIT_IDLE));
  assign status = {3'b000, ovr_q, to_q, le_q, pe_q, dr_q, 7'd0, active};
  assign irq    = cfg_q[0] & (|status[12:8]);
  assign unused_d_in = ^{d_in[31:29], d_in[23:16], d_in[15:11]};

  // Half-bit length in clocks selected by FQ.
  always_comb begin
    case (fq)
      3'd0:    hb = 6'd2;
      3'd1:    hb = 6'd4;
      3'd2:    hb = 6'd8;
      3'd3:    hb = 6'd16;
      3'd4:    hb = 6'd32;
      default: hb = 6'd2;
    endcase
  end

  // Config register; the whole write is dropped unless BQ is legal and no frame is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= 11'h210;
    end else if (cfg_ok) begin
      cfg_q <= d_in[10:0];
    end
  end

  // Frame FSM with phase timer, status flags and rxdata; flag sets override same-cycle clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_IDLE;
      ln_q     <= LN_STOP;
      sym_q    <= LN_IDLE;
      tmr_q    <= 16'd0;
      shift_q  <= 33'd0;
      n_q      <= 6'd0;
      rxdata_q <= 32'd0;
      dr_q     <= 1'b0;
      pe_q     <= 1'b0;
      le_q     <= 1'b0;
      to_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      ln_q <= line;
      if (!active || (line != ln_q)) tmr_q <= 16'd0;
      else                           tmr_q <= tmr_q + 16'd1;
      if (reg_wr) begin
        if (!d_in[24]) dr_q  <= 1'b0;
        if (!d_in[25]) pe_q  <= 1'b0;
        if (!d_in[26]) le_q  <= 1'b0;
        if (!d_in[27]) to_q  <= 1'b0;
        if (!d_in[28]) ovr_q <= 1'b0;
      end
      case (state_q)
        WAIT_IDLE: begin
          if (line == LN_IDLE) state_q <= IDLE;
        end
        IDLE: begin
          if ((line == LN_ZERO) || (line == LN_ONE)) begin
            state_q <= SYMBOL;
            sym_q   <= line;
            shift_q <= {32'd0, bit_s};
            n_q     <= 6'd1;
          end else if (line == LN_STOP) begin
            state_q <= WAIT_IDLE;
          end
        end
        SYMBOL: begin
          if (line == LN_IDLE) begin
            state_q <= GAP;
          end else if (line != sym_q) begin
            le_q    <= 1'b1;
            state_q <= WAIT_IDLE;
          end else if (tmo) begin
            to_q    <= 1'b1;
            state_q <= WAIT_IDLE;
          end
        end
        GAP: begin
          if ((line == LN_ZERO) || (line == LN_ONE)) begin
            if (n_q > bq) begin
              le_q    <= 1'b1;
              state_q <= WAIT_IDLE;
            end else begin
              shift_q[n_q] <= bit_s;
              n_q          <= n_q + 6'd1;
              sym_q        <= line;
              state_q      <= SYMBOL;
            end
          end else if (line == LN_STOP) begin
            state_q <= STOP;
          end else if (tmo) begin
            to_q    <= 1'b1;
            state_q <= WAIT_IDLE;
          end
        end
        STOP: begin
          if (line == LN_IDLE) begin
            state_q <= IDLE;
            if (n_q != (bq + 6'd1)) begin
              le_q <= 1'b1;
            end else if (!parity_ok(shift_q, bq)) begin
              pe_q <= 1'b1;
            end else begin
              rxdata_q <= data_of(shift_q, bq);
              dr_q     <= 1'b1;
              if (dr_q) ovr_q <= 1'b1;
            end
          end else if (line != LN_STOP) begin
            le_q    <= 1'b1;
            state_q <= WAIT_IDLE;
          end else if (tmo) begin
            to_q    <= 1'b1;
            state_q <= WAIT_IDLE;
          end
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  // Register read mux.
  always_comb begin
    if (addr) d_out = rxdata_q;
    else      d_out = {status, 5'd0, cfg_q};
  end

endmodule

// File: tb/tb_sl_receiver.sv
`timescale 1ns/1ps
module tb_sl_receiver;
  localparam int SYNC = 2;
`ifdef SL_RX_FILTER_EN
  localparam int LAT = SYNC + 3;
`else
  localparam int LAT = SYNC + 1;
`endif
  localparam int HB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SL0 = 1'b1;
  logic        SL1 = 1'b1;
  logic [31:0] d_in = 32'd0;
  logic        addr = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] d_out;
  logic        irq;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] sb[$];

  sl_receiver #(.SYNC_STAGES(SYNC), .TO_MULT(4)) dut (
    .clk(clk), .rst_n(rst_n), .SL0(SL0), .SL1(SL1),
    .d_in(d_in), .addr(addr), .wr_en(wr_en), .d_out(d_out), .irq(irq)
  );

  always #31.25 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic a, output logic [31:0] v);
    addr = a;
    #1;
    v = d_out;
  endtask

  task automatic rd_status(output logic [15:0] s);
    logic [31:0] v;
    rd(1'b0, v);
    s = v[31:16];
  endtask

  task automatic wr(input logic [31:0] v);
    @(negedge clk);
    addr = 1'b0; d_in = v; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; d_in = 32'd0;
  endtask

  task automatic drive(input logic l1, input logic l0, input int n);
    SL1 = l1; SL0 = l0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic par_of(input logic [31:0] d, input int nb);
    logic p;
    p = 1'b1;
    for (int i = 0; i < nb; i++) p = p ^ d[i];
    return p;
  endfunction

  // nb data symbols LSB first, parity symbol, stop, then lines back to idle.
  task automatic send(input logic [31:0] d, input int nb, input logic par);
    for (int i = 0; i < nb; i++) begin
      drive(~d[i], d[i], HB);
      drive(1'b1, 1'b1, HB);
    end
    drive(~par, par, HB);
    drive(1'b1, 1'b1, HB);
    drive(1'b0, 1'b0, HB);
    SL1 = 1'b1; SL0 = 1'b1;
  endtask

  task automatic expect_good(input string tag, input logic chk_early);
    logic [15:0] s;
    logic [31:0] v, exp;
    repeat (LAT - 1) @(posedge clk);
    #1;
    if (chk_early) begin
      rd_status(s);
      check({tag, "_dr_early"}, {31'd0, s[8]}, 32'd0);
    end
    @(posedge clk);
    #1;
    rd_status(s);
    check({tag, "_dr"}, {31'd0, s[8]}, 32'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hBAD0_BAD0;
    rd(1'b1, v);
    check({tag, "_rxdata"}, v, exp);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;
    logic [15:0] s;
    logic [31:0] bad_cfg [3];
    logic [31:0] w;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Reset state
    rd(1'b0, v); check("rst_reg0", v, 32'h0000_0210);
    rd(1'b1, v); check("rst_rxdata", v, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // Illegal BQ values (34, odd 7, 6) leave config untouched
    bad_cfg[0] = 32'hFFFF_0244; bad_cfg[1] = 32'hFFFF_020E; bad_cfg[2] = 32'hFFFF_020C;
    for (int i = 0; i < 3; i++) begin
      wr(bad_cfg[i]);
      rd(1'b0, v); check("cfg_reject", {16'd0, v[15:0]}, 32'h0000_0210);
    end

    // 1: BQ=8 good frame
    w = 32'h0000_00A5;
    sb.push_back(w);
    send(w, 8, 1'b1);
    expect_good("t1", 1'b1);
    rd_status(s); check("t1_status", {16'd0, s}, 32'h0000_0100);

    // 2: BQ=32, IRQM=1
    wr(32'hFFFF_0241);
    rd(1'b0, v); check("t2_cfg", {16'd0, v[15:0]}, 32'h0000_0241);
    check("t2_irq_old_dr", {31'd0, irq}, 32'd1);
    wr(32'h0000_0241);
    check("t2_irq_cleared", {31'd0, irq}, 32'd0);
    w = 32'hDEAD_BEEF;
    sb.push_back(w);
    send(w, 32, par_of(w, 32));
    expect_good("t2", 1'b1);
    check("t2_irq_set", {31'd0, irq}, 32'd1);
    wr(32'hFEFF_0241);
    rd_status(s); check("t2_dr_clr", {31'd0, s[8]}, 32'd0);
    check("t2_irq_fall", {31'd0, irq}, 32'd0);

    // 3: parity error, too many symbols, too few symbols
    wr(32'h0000_0211);
    send(32'h01, 8, 1'b1);
    repeat (LAT + 1) @(posedge clk); #1;
    rd_status(s); check("t3_pe", {16'd0, s}, 32'h0000_0200);
    rd(1'b1, v); check("t3_pe_rx", v, 32'hDEAD_BEEF);
    check("t3_irq", {31'd0, irq}, 32'd1);
    @(negedge clk);
    wr(32'h0000_0211);
    send(32'h1AA, 9, 1'b0);
    repeat (LAT + 1) @(posedge clk); #1;
    rd_status(s); check("t3_le_long", {16'd0, s}, 32'h0000_0400);
    rd(1'b1, v); check("t3_le_rx", v, 32'hDEAD_BEEF);
    @(negedge clk);
    wr(32'h0000_0211);
    send(32'h05, 6, 1'b1);
    repeat (LAT + 1) @(posedge clk); #1;
    rd_status(s); check("t3_le_short", {16'd0, s}, 32'h0000_0400);
    @(negedge clk);

    // 4: SL1 stuck low for 40 clocks -> timeout after 32 clocks in SYMBOL
    wr(32'h0000_0211);
    SL1 = 1'b0; SL0 = 1'b1;
    repeat (LAT + 31) @(posedge clk); #1;
    rd_status(s); check("t4_pre_to", {16'd0, s}, 32'h0000_0001);
    @(posedge clk); #1;
    rd_status(s); check("t4_to", {16'd0, s}, 32'h0000_0800);
    @(negedge clk);
    repeat (4) @(negedge clk);
    drive(1'b1, 1'b1, HB);
    rd_status(s); check("t4_after", {16'd0, s}, 32'h0000_0800);
    wr(32'h0000_0211);
    w = 32'h0000_003C;
    sb.push_back(w);
    send(w, 8, par_of(w, 8));
    expect_good("t4", 1'b1);

    // 5: overrun, then DR clear in the same cycle DR sets
    wr(32'h0000_0211);
    w = 32'h0000_005A; sb.push_back(w); send(w, 8, par_of(w, 8));
    expect_good("t5a", 1'b1);
    w = 32'h0000_00C3; sb.push_back(w); send(w, 8, par_of(w, 8));
    expect_good("t5b", 1'b0);
    rd_status(s); check("t5_ovr", {16'd0, s}, 32'h0000_1100);
    wr(32'h0000_0211);
    w = 32'h0000_0096; sb.push_back(w); send(w, 8, par_of(w, 8));
    repeat (LAT - 1) @(posedge clk);
    #1;
    addr = 1'b0; d_in = 32'hFEFF_0211; wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0; d_in = 32'd0;
    rd_status(s); check("t5_set_wins", {16'd0, s}, 32'h0000_0100);
    rd(1'b1, v); check("t5_rx", v, sb.pop_front());
    @(negedge clk);

    // 6: reset asserted and released in the middle of a symbol
    w = 32'h0000_003C;
    for (int i = 0; i < 2; i++) begin
      drive(~w[i], w[i], HB);
      drive(1'b1, 1'b1, HB);
    end
    drive(~w[2], w[2], 3);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rd(1'b0, v); check("t6_rst_reg0", v, 32'h0000_0210);
    rd(1'b1, v); check("t6_rst_rx", v, 32'd0);
    check("t6_rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    drive(~w[2], w[2], 3);
    drive(1'b1, 1'b1, HB);
    for (int i = 3; i < 8; i++) begin
      drive(~w[i], w[i], HB);
      drive(1'b1, 1'b1, HB);
    end
    drive(~par_of(w, 8), par_of(w, 8), HB);
    drive(1'b1, 1'b1, HB);
    drive(1'b0, 1'b0, HB);
    SL1 = 1'b1; SL0 = 1'b1;
    repeat (LAT + 2) @(posedge clk); #1;
    rd(1'b1, v); check("t6_partial_rx", v, 32'd0);
    rd_status(s); check("t6_partial_dr", {31'd0, s[8]}, 32'd0);
    @(negedge clk);
    wr(32'h0000_0210);
    w = 32'h0000_00E7; sb.push_back(w); send(w, 8, par_of(w, 8));
    expect_good("t6", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
